// File: rtl/ones_window_accum.sv
// Ones-density monitor: popcounts a byte stream and sums it per window.
// Emits one record per window (full or closed early by in_last).
module ones_window_accum #(
    parameter int unsigned WIN_LEN = 16,
    parameter int unsigned HI_TH   = 96,
    parameter int unsigned LO_TH   = 32,
    parameter int unsigned CNT_W   = $clog2(8 * WIN_LEN + 1),
    parameter int unsigned BYTE_W  = $clog2(WIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic [BYTE_W-1:0] out_bytes,
    output logic              out_hi,
    output logic              out_lo,
    output logic              out_short
);

    function automatic logic [3:0] f_popcount(input logic [7:0] d);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, d[i]};
        end
        return s;
    endfunction

    logic [3:0]        r_pc;
    logic              r_v1;
    logic              r_last1;
    logic [CNT_W-1:0]  r_acc;
    logic [BYTE_W-1:0] r_bcnt;
    logic              r_fresh;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_out_count;
    logic [BYTE_W-1:0] r_out_bytes;
    logic              r_out_hi;
    logic              r_out_lo;
    logic              r_out_short;

    logic              w_en;
    logic              w_accept;
    logic [CNT_W-1:0]  w_acc_next;
    logic [BYTE_W-1:0] w_bcnt_next;
    logic              w_close;

    // A held record stalls the whole pipe, so nothing upstream can be lost.
    assign w_en     = !r_out_valid || out_ready;
    assign w_accept = in_valid && w_en;
    assign in_ready = w_en;

    always_comb begin
        w_acc_next  = r_acc + CNT_W'(r_pc);
        w_bcnt_next = r_bcnt + BYTE_W'(1);
        if (r_fresh) begin
            w_acc_next  = CNT_W'(r_pc);
            w_bcnt_next = BYTE_W'(1);
        end
    end

    assign w_close = r_v1 &&
                     (r_last1 || (w_bcnt_next == BYTE_W'(WIN_LEN)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
        end else if (w_en) begin
            r_pc    <= f_popcount(in_data);
            r_v1    <= w_accept;
            r_last1 <= w_accept && in_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_bcnt  <= '0;
            r_fresh <= 1'b1;
        end else if (w_en && r_v1) begin
            r_acc   <= w_acc_next;
            r_bcnt  <= w_bcnt_next;
            r_fresh <= w_close;
        end
    end

    // With en high the register is either empty or draining this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_count <= '0;
            r_out_bytes <= '0;
            r_out_hi    <= 1'b0;
            r_out_lo    <= 1'b0;
            r_out_short <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= w_close;
            if (w_close) begin
                r_out_count <= w_acc_next;
                r_out_bytes <= w_bcnt_next;
                r_out_hi    <= 32'(w_acc_next) >= HI_TH;
                r_out_lo    <= 32'(w_acc_next) <= LO_TH;
                r_out_short <= 32'(w_bcnt_next) < WIN_LEN;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_count = r_out_count;
    assign out_bytes = r_out_bytes;
    assign out_hi    = r_out_hi;
    assign out_lo    = r_out_lo;
    assign out_short = r_out_short;

endmodule

// File: tb/tb_ones_window_accum.sv
// Bench for ones_window_accum: window-sum model plus directed vectors.
// Records are checked every valid cycle and logged at handshake.
module tb_ones_window_accum;

    localparam int WIN_LEN = 16;
    localparam int HI_TH   = 96;
    localparam int LO_TH   = 32;
    localparam int CNT_W   = $clog2(8 * WIN_LEN + 1);
    localparam int BYTE_W  = $clog2(WIN_LEN + 1);

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic [BYTE_W-1:0] out_bytes;
    logic              out_hi;
    logic              out_lo;
    logic              out_short;

    ones_window_accum #(
        .WIN_LEN(WIN_LEN),
        .HI_TH  (HI_TH),
        .LO_TH  (LO_TH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_count(out_count),
        .out_bytes(out_bytes),
        .out_hi   (out_hi),
        .out_lo   (out_lo),
        .out_short(out_short)
    );

    typedef struct {
        int cnt;
        int bytes;
        bit hi;
        bit lo;
        bit sh;
        int due;
    } rec_t;

    rec_t exp_q[$];
    rec_t log_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   m_sum    = 0;
    int   m_n      = 0;
    int   acc_tot  = 0;
    int   stall_cy = 0;
    bit   shown    = 0;
    bit   stall_arm = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Model: sum popcounts of accepted bytes, close on WIN_LEN or in_last.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_sum = 0;
            m_n   = 0;
            shown = 0;
            exp_q.delete();
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_count", int'(out_count), 0);
            chk("rst_out_bytes", int'(out_bytes), 0);
            chk("rst_flags", int'({out_hi, out_lo, out_short}), 0);
        end else begin
            cyc++;
            chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", int'(out_valid), 0);
                end else begin
                    if (!shown) begin
                        chk("latency", cyc, exp_q[0].due);
                        shown = 1;
                    end
                    chk("out_count", int'(out_count), exp_q[0].cnt);
                    chk("out_bytes", int'(out_bytes), exp_q[0].bytes);
                    chk("out_hi", int'(out_hi), int'(exp_q[0].hi));
                    chk("out_lo", int'(out_lo), int'(exp_q[0].lo));
                    chk("out_short", int'(out_short), int'(exp_q[0].sh));
                    if (out_ready) begin
                        log_q.push_back(exp_q[0]);
                        void'(exp_q.pop_front());
                        shown = 0;
                    end
                end
            end
            if (in_valid && !in_ready) stall_cy++;
            if (in_valid && in_ready) begin
                rec_t r;
                acc_tot++;
                m_sum += $countones(in_data);
                m_n++;
                if (m_n == WIN_LEN || in_last) begin
                    r.cnt   = m_sum;
                    r.bytes = m_n;
                    r.hi    = m_sum >= HI_TH;
                    r.lo    = m_sum <= LO_TH;
                    r.sh    = m_n < WIN_LEN;
                    r.due   = cyc + 2;
                    exp_q.push_back(r);
                    m_sum = 0;
                    m_n   = 0;
                end
            end
        end
    end

    // Backpressure: hold out_ready low 5 cycles when a record shows up.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_arm && out_valid) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
                stall_arm = 0;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 100);
        if (!in_ready) chk("send_timeout", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_n(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) send(d, 1'b0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_rec(input string name, input int idx, input int c,
                           input int b, input int hi, input int lo,
                           input int sh);
        if (idx >= log_q.size()) begin
            chk({name, "_present"}, log_q.size(), idx + 1);
        end else begin
            chk({name, "_count"}, log_q[idx].cnt, c);
            chk({name, "_bytes"}, log_q[idx].bytes, b);
            chk({name, "_hi"}, int'(log_q[idx].hi), hi);
            chk({name, "_lo"}, int'(log_q[idx].lo), lo);
            chk({name, "_short"}, int'(log_q[idx].sh), sh);
        end
    endtask

    initial begin
        int base;
        int a0;
        int s0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_out_count", int'(out_count), 0);
        chk("idle_in_ready", int'(in_ready), 1);

        base = log_q.size();
        send_n(8'hFF, 16);
        idle(6);
        chk("t_ff_nrec", log_q.size(), base + 1);
        chk_rec("t_ff", base, 128, 16, 1, 0, 0);

        base = log_q.size();
        for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 8'h01 : 8'h00, 1'b0);
        send_n(8'hAA, 16);
        idle(6);
        chk("t_alt_nrec", log_q.size(), base + 2);
        chk_rec("t_alt", base, 8, 16, 0, 1, 0);
        chk_rec("t_aa", base + 1, 64, 16, 0, 0, 0);

        base = log_q.size();
        send(8'h0F, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h81, 1'b1);
        send_n(8'hFF, 16);
        idle(6);
        chk("t_short_nrec", log_q.size(), base + 2);
        chk_rec("t_short", base, 10, 3, 0, 1, 1);
        chk_rec("t_fresh", base + 1, 128, 16, 1, 0, 0);

        base = log_q.size();
        a0 = acc_tot;
        s0 = stall_cy;
        stall_arm = 1;
        send_n(8'h77, 32);
        idle(8);
        chk("t_bp_nrec", log_q.size(), base + 2);
        chk("t_bp_accepted", acc_tot - a0, 32);
        chk("t_bp_stall_cycles", stall_cy - s0, 5);
        chk_rec("t_bp0", base, 96, 16, 1, 0, 0);
        chk_rec("t_bp1", base + 1, 96, 16, 1, 0, 0);

        base = log_q.size();
        send_n(8'hFF, 5);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send_n(8'h03, 16);
        idle(6);
        chk("t_rst_nrec", log_q.size(), base + 1);
        chk_rec("t_rst", base, 32, 16, 0, 1, 0);

        chk("final_pending", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
